// File: rtl/trace_pkg.sv
// trace_pkg: shared state type, entry-width helper and default halt word for the trace monitor.
package trace_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} trace_state_t;
  localparam logic [31:0] HALT_BA = 32'h1080_0000;
  function automatic int trace_entry_w(input int ts_w, input int addr_w, input int lanes);
    return ts_w + addr_w + lanes * 9;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: generic synchronous first-word-fall-through FIFO with occupancy and flush.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop);
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
    end
  end
endmodule

// File: rtl/mem_trace_monitor.sv
// mem_trace_monitor: captures qualified RAM writes into a trace FIFO until the halt word appears on the IR bus.
module mem_trace_monitor
  import trace_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          LANES     = 4,
  parameter int          DEPTH     = 16,
  parameter int          TS_W      = 16,
  parameter logic [31:0] HALT_WORD = HALT_BA
) (
  input  logic                                         Clk,
  input  logic                                         RESET_n,
  input  logic                                         arm,
  input  logic                                         clear,
  input  logic                                         mem_enable,
  input  logic                                         mem_write,
  input  logic [ADDR_W-1:0]                            mem_addr,
  input  logic [LANES*8-1:0]                           mem_wdata,
  input  logic [LANES-1:0]                             mem_be,
  input  logic                                         ir_load,
  input  logic [31:0]                                  ir_word,
  input  logic                                         rd_en,
  output logic [trace_entry_w(TS_W, ADDR_W, LANES)-1:0] rd_data,
  output logic                                         empty,
  output logic                                         full,
  output logic [$clog2(DEPTH):0]                       level,
  output logic                                         overflow,
  output logic                                         halted,
  output logic [TS_W-1:0]                              events
);
  trace_state_t state, state_n;
  logic qual, capture, halt_hit;
  assign qual     = mem_enable & mem_write & |mem_be;
  assign capture  = (state == RUN) & qual & ~clear;
  assign halt_hit = ir_load & (ir_word == HALT_WORD);
  assign halted   = state == HALT;
  always_comb begin
    state_n = state;
    if (clear) state_n = IDLE;
    else if (state == IDLE && arm) state_n = RUN;
    else if (state == RUN && halt_hit) state_n = HALT;
  end
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else state <= state_n;
  end
  // Timestamp is the event count before this write is counted.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      events   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      events   <= '0;
      overflow <= 1'b0;
    end else if (capture) begin
      events   <= (events == '1) ? events : events + 1'b1;
      overflow <= overflow | (full & ~rd_en);
    end
  end
  trace_fifo #(
    .WIDTH(trace_entry_w(TS_W, ADDR_W, LANES)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (Clk),
    .rst_n  (RESET_n),
    .flush  (clear),
    .push   (capture),
    .wdata  ({events, mem_addr, mem_wdata, mem_be}),
    .pop    (rd_en),
    .rd_data(rd_data),
    .empty  (empty),
    .full   (full),
    .level  (level)
  );
endmodule

// File: tb/tb_mem_trace_monitor.sv
// tb_mem_trace_monitor: scoreboard bench; expected entries are queued as writes are driven and checked on pop.
module tb_mem_trace_monitor;
  import trace_pkg::*;
  localparam int ADDR_W = 32, LANES = 4, DEPTH = 16, TS_W = 16;
  localparam int EW = TS_W + ADDR_W + LANES * 9;
  localparam int LW = $clog2(DEPTH) + 1;
  typedef logic [EW-1:0] entry_t;

  logic Clk = 0, RESET_n = 0;
  logic arm = 0, clear = 0, mem_enable = 0, mem_write = 0, ir_load = 0, rd_en = 0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [LANES*8-1:0] mem_wdata = '0;
  logic [LANES-1:0] mem_be = '0;
  logic [31:0] ir_word = '0;
  entry_t rd_data;
  logic empty, full, overflow, halted;
  logic [LW-1:0] level;
  logic [TS_W-1:0] events;

  int tests = 0, fails = 0;
  entry_t sb[$];
  trace_state_t m_state = IDLE;
  logic [TS_W-1:0] m_events = '0;
  logic m_ovf = 0;

  mem_trace_monitor #(.ADDR_W(ADDR_W), .LANES(LANES), .DEPTH(DEPTH), .TS_W(TS_W), .HALT_WORD(32'h1080_0000)) dut (
    .Clk(Clk), .RESET_n(RESET_n), .arm(arm), .clear(clear), .mem_enable(mem_enable), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .ir_load(ir_load), .ir_word(ir_word),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .level(level), .overflow(overflow),
    .halted(halted), .events(events)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input logic a, input logic c, input logic en, input logic w, input logic [ADDR_W-1:0] ad,
                      input logic [LANES*8-1:0] d, input logic [LANES-1:0] b, input logic il,
                      input logic [31:0] iw, input logic r);
    logic cap, popok;
    arm = a; clear = c; mem_enable = en; mem_write = w; mem_addr = ad; mem_wdata = d; mem_be = b;
    ir_load = il; ir_word = iw; rd_en = r;
    cap = (m_state == RUN) && en && w && (b != 0);
    if (c) begin
      sb.delete(); m_events = '0; m_ovf = 0; m_state = IDLE;
    end else begin
      popok = r && sb.size() > 0;
      if (popok) void'(sb.pop_front());
      if (cap) begin
        if (sb.size() < DEPTH) sb.push_back({m_events, ad, d, b});
        else m_ovf = 1;
        if (m_events != '1) m_events = m_events + 1'b1;
      end
      if (m_state == IDLE && a) m_state = RUN;
      else if (m_state == RUN && il && iw == 32'h1080_0000) m_state = HALT;
    end
    @(posedge Clk); #1;
    arm = 0; clear = 0; mem_enable = 0; mem_write = 0; mem_be = '0; ir_load = 0; rd_en = 0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] ad, input logic [31:0] d, input logic [3:0] b);
    step(0, 0, 1, 1, ad, d, b, 0, 0, 0);
  endtask
  task automatic do_arm();  step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_clear(); step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_pop();  step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask

  task automatic test_reset();
    RESET_n = 0;
    repeat (2) @(posedge Clk);
    #1 RESET_n = 1;
    sb.delete(); m_events = '0; m_ovf = 0; m_state = IDLE;
    @(posedge Clk); #1;
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
    tests++; if (level !== '0) begin fails++; $display("FAIL reset_level got %0d exp 0", level); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b exp 0", halted); end
    tests++; if (events !== '0) begin fails++; $display("FAIL reset_events got %0d exp 0", events); end
    tests++; if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
  endtask

  task automatic test_basic();
    do_arm();
    wr(32'h2C, 32'hDEAD_0001, 4'hF);
    wr(32'h30, 32'hDEAD_0002, 4'hF);
    wr(32'h34, 32'hDEAD_0003, 4'hF);
    tests++; if (level !== 3) begin fails++; $display("FAIL basic_level got %0d exp 3", level); end
    tests++; if (events !== 3) begin fails++; $display("FAIL basic_events got %0d exp 3", events); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (rd_data !== sb[0]) begin fails++; $display("FAIL basic_pop%0d got %h exp %h", i, rd_data, sb[0]); end
      tests++; if (rd_data[EW-1 -: TS_W] !== TS_W'(i)) begin fails++; $display("FAIL basic_ts%0d got %0d exp %0d", i, rd_data[EW-1 -: TS_W], i); end
      do_pop();
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL basic_empty got %b exp 1", empty); end
    do_pop();
    tests++; if (level !== 0) begin fails++; $display("FAIL basic_pop_on_empty level got %0d exp 0", level); end
  endtask

  task automatic test_nonqual();
    do_clear(); do_arm();
    wr(32'h40, 32'h1234_5678, 4'h0);
    step(0, 0, 1, 0, 32'h44, 32'h0, 4'hF, 0, 0, 0);
    tests++; if (events !== 0) begin fails++; $display("FAIL nonqual_events got %0d exp 0", events); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL nonqual_empty got %b exp 1", empty); end
  endtask

  task automatic test_arm_write();
    do_clear();
    step(1, 0, 1, 1, 32'h50, 32'hAAAA_5555, 4'h3, 0, 0, 0);
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL armwr_empty got %b exp 1", empty); end
    tests++; if (events !== 0) begin fails++; $display("FAIL armwr_events got %0d exp 0", events); end
    wr(32'h54, 32'h0BAD_F00D, 4'h3);
    tests++; if (rd_data !== sb[0]) begin fails++; $display("FAIL armwr_head got %h exp %h", rd_data, sb[0]); end
  endtask

  task automatic test_overflow();
    do_clear(); do_arm();
    for (int i = 0; i < 18; i++) wr(32'h100 + 4 * i, $urandom, 4'(1 + i % 15));
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full got %b exp 1", full); end
    tests++; if (level !== 16) begin fails++; $display("FAIL ovf_level got %0d exp 16", level); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    tests++; if (events !== 18) begin fails++; $display("FAIL ovf_events got %0d exp 18", events); end
    for (int i = 0; i < 16; i++) begin
      tests++; if (rd_data !== sb[0] || rd_data[EW-1 -: TS_W] !== TS_W'(i)) begin
        fails++; $display("FAIL ovf_pop%0d got %h exp %h", i, rd_data, sb[0]);
      end
      do_pop();
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ovf_drained got %b exp 1", empty); end
  endtask

  task automatic test_back_to_back();
    do_clear(); do_arm();
    for (int i = 0; i < 16; i++) wr(32'h200 + 4 * i, 32'hC000_0000 + i, 4'hF);
    tests++; if (rd_data !== sb[0]) begin fails++; $display("FAIL b2b_head got %h exp %h", rd_data, sb[0]); end
    step(0, 0, 1, 1, 32'h300, 32'hFEED_BEEF, 4'hF, 0, 0, 1);
    tests++; if (level !== 16) begin fails++; $display("FAIL b2b_level got %0d exp 16", level); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_overflow got %b exp 0", overflow); end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL b2b_full got %b exp 1", full); end
    for (int i = 0; i < 16; i++) begin
      tests++; if (rd_data !== sb[0]) begin fails++; $display("FAIL b2b_pop%0d got %h exp %h", i, rd_data, sb[0]); end
      if (i == 15) begin
        tests++; if (rd_data[ADDR_W+LANES*9-1 -: ADDR_W] !== 32'h300) begin
          fails++; $display("FAIL b2b_tail_addr got %h exp 300", rd_data[ADDR_W+LANES*9-1 -: ADDR_W]);
        end
      end
      do_pop();
    end
  endtask

  task automatic test_halt();
    do_clear(); do_arm();
    wr(32'h2C, 32'h1111_1111, 4'hF);
    step(0, 0, 1, 1, 32'h31, 32'h2222_2222, 4'h2, 1, 32'h1080_0000, 0);
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag got %b exp 1", halted); end
    tests++; if (level !== 2) begin fails++; $display("FAIL halt_level got %0d exp 2", level); end
    wr(32'h38, 32'h3333_3333, 4'hF);
    do_arm();
    wr(32'h3C, 32'h4444_4444, 4'hF);
    tests++; if (events !== 2) begin fails++; $display("FAIL halt_events got %0d exp 2", events); end
    tests++; if (level !== 2) begin fails++; $display("FAIL halt_frozen_level got %0d exp 2", level); end
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_arm_ignored got %b exp 1", halted); end
    for (int i = 0; i < 2; i++) begin
      tests++; if (rd_data !== sb[0]) begin fails++; $display("FAIL halt_pop%0d got %h exp %h", i, rd_data, sb[0]); end
      do_pop();
    end
    wr(32'h40, 32'h5555_5555, 4'hF);
    do_clear();
    tests++; if (halted !== 1'b0 || events !== 0 || level !== 0 || overflow !== 1'b0) begin
      fails++; $display("FAIL halt_clear got h=%b e=%0d l=%0d o=%b exp 0/0/0/0", halted, events, level, overflow);
    end
    wr(32'h44, 32'h6666_6666, 4'hF);
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL halt_idle_nocap got %b exp 1", empty); end
  endtask

  task automatic test_async_reset();
    do_clear(); do_arm();
    for (int i = 0; i < 5; i++) wr(32'h500 + 4 * i, 32'h7000_0000 + i, 4'hF);
    tests++; if (level !== 5) begin fails++; $display("FAIL arst_pre_level got %0d exp 5", level); end
    #2 RESET_n = 0;
    #1;
    tests++; if (level !== 0 || empty !== 1'b1 || halted !== 1'b0 || events !== 0) begin
      fails++; $display("FAIL arst_async got l=%0d e=%b h=%b ev=%0d exp 0/1/0/0", level, empty, halted, events);
    end
    #2 RESET_n = 1;
    sb.delete(); m_events = '0; m_ovf = 0; m_state = IDLE;
    @(posedge Clk); #1;
    wr(32'h600, 32'h8888_8888, 4'hF);
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL arst_idle got %b exp 1", empty); end
    tests++; if (level !== LW'(sb.size()) || events !== m_events || overflow !== m_ovf) begin
      fails++; $display("FAIL arst_model got l=%0d ev=%0d o=%b exp %0d/%0d/%b", level, events, overflow, sb.size(), m_events, m_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nonqual();
    test_arm_write();
    test_overflow();
    test_back_to_back();
    test_halt();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
